// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: a five-state level FSM advanced on sample ticks,
// plus a registered multiplier that scales each input sample by the pre-update level.
module adsr_envelope #(
    parameter int unsigned ATTACK_STEP   = 4,
    parameter int unsigned DECAY_STEP    = 1,
    parameter int unsigned SUSTAIN_LEVEL = 192,
    parameter int unsigned RELEASE_STEP  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        note_on,
    input  logic        note_off,
    input  logic [17:0] sample_in,
    input  logic        sample_in_valid,
    output logic [17:0] sample_out,
    output logic        sample_out_valid,
    output logic [8:0]  env_level,
    output logic        envelope_active
);

    localparam int unsigned LW = 10;
    localparam int unsigned PW = 27;
    localparam int unsigned SW = 18;

    localparam logic [LW-1:0] MAX_LVL = LW'(256);
    localparam logic [LW-1:0] ATK_INC = LW'(ATTACK_STEP);
    localparam logic [LW-1:0] DEC_INC = LW'(DECAY_STEP);
    localparam logic [LW-1:0] SUS_LVL = LW'(SUSTAIN_LEVEL);
    localparam logic [LW-1:0] REL_INC = LW'(RELEASE_STEP);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]           r_state;
    logic [LW-1:0]        r_level;
    logic                 r_active;
    logic [SW-1:0]        r_sample_out;
    logic                 r_sample_out_valid;

    logic [2:0]           w_state_nxt;
    logic [LW-1:0]        w_level_nxt;
    logic [LW-1:0]        w_atk_sum;
    logic                 w_gate_held;
    logic signed [PW-1:0] w_mult_a;
    logic signed [PW-1:0] w_mult_b;
    logic signed [PW-1:0] w_prod;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_level  <= '0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_level  <= w_level_nxt;
            r_active <= (w_state_nxt != S_IDLE);
        end
    end

    assign w_gate_held = (r_state == S_ATTACK) || (r_state == S_DECAY) ||
                         (r_state == S_SUSTAIN);

    // Next state and level; note events preempt the tick step on the same edge
    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_atk_sum   = r_level + ATK_INC;
        if (note_on) begin
            w_state_nxt = S_ATTACK;
        end else if (note_off && w_gate_held) begin
            w_state_nxt = S_RELEASE;
        end else if (sample_in_valid) begin
            case (r_state)
                S_ATTACK: begin
                    if (w_atk_sum >= MAX_LVL) begin
                        w_level_nxt = MAX_LVL;
                        w_state_nxt = S_DECAY;
                    end else begin
                        w_level_nxt = w_atk_sum;
                    end
                end
                S_DECAY: begin
                    if (r_level > SUS_LVL + DEC_INC) begin
                        w_level_nxt = r_level - DEC_INC;
                    end else begin
                        w_level_nxt = SUS_LVL;
                        w_state_nxt = S_SUSTAIN;
                    end
                end
                S_SUSTAIN: begin
                    w_level_nxt = SUS_LVL;
                end
                S_RELEASE: begin
                    if (r_level > REL_INC) begin
                        w_level_nxt = r_level - REL_INC;
                    end else begin
                        w_level_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_level_nxt = '0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Level never exceeds 256, so the signed 27-bit product cannot overflow
    assign w_mult_a = PW'($signed(sample_in));
    assign w_mult_b = PW'($signed({1'b0, r_level[8:0]}));
    assign w_prod   = w_mult_a * w_mult_b;

    // Output sample register; holds its value between ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample_out       <= '0;
            r_sample_out_valid <= 1'b0;
        end else begin
            r_sample_out_valid <= sample_in_valid;
            if (sample_in_valid) begin
                r_sample_out <= SW'(w_prod >>> 8);
            end
        end
    end

    assign sample_out       = r_sample_out;
    assign sample_out_valid = r_sample_out_valid;
    assign env_level        = r_level[8:0];
    assign envelope_active  = r_active;

endmodule

// File: doc/adsr_envelope.md
ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 The block SHALL have parameter ATTACK_STEP, default 4, meaning the level increment per input sample in ATTACK.
REQ-002 The block SHALL have parameter DECAY_STEP, default 1, meaning the level decrement per input sample in DECAY.
REQ-003 The block SHALL have parameter SUSTAIN_LEVEL, default 192, meaning the DECAY floor and SUSTAIN hold level; legal range is 0..256.
REQ-004 The block SHALL have parameter RELEASE_STEP, default 2, meaning the level decrement per input sample in RELEASE.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port note_on, input, 1 bit: single-cycle pulse that starts or retriggers ATTACK.
REQ-008 The block SHALL have port note_off, input, 1 bit: single-cycle pulse that starts RELEASE.
REQ-009 The block SHALL have port sample_in, input, 18 bits: signed two's-complement harmonic sample from the synthesis stage.
REQ-010 The block SHALL have port sample_in_valid, input, 1 bit: sample_in valid; driven by the upstream sample_ready.
REQ-011 The block SHALL have port sample_out, output, 18 bits: signed enveloped sample.
REQ-012 The block SHALL have port sample_out_valid, output, 1 bit: one-cycle pulse marking a new sample_out.
REQ-013 The block SHALL have port env_level, output, 9 bits: current envelope level, unsigned, 0..256.
REQ-014 The block SHALL have port envelope_active, output, 1 bit: high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, ATTACK, DECAY, SUSTAIN and RELEASE.
REQ-016 A level tick SHALL be any cycle with sample_in_valid=1; the level changes only on ticks, except on reset.
REQ-017 A note_on in any state SHALL move the FSM to ATTACK at that edge, keeping the current level (no reset to 0), with no level step that edge.
REQ-018 A note_off in ATTACK, DECAY or SUSTAIN SHALL move the FSM to RELEASE at that edge, with no level step that edge.
REQ-019 A note_off in IDLE or RELEASE SHALL be ignored.
REQ-020 If note_on and note_off arrive in the same cycle, note_on SHALL take priority.
REQ-021 On an ATTACK tick, level SHALL become min(level+ATTACK_STEP, 256); on reaching 256 the FSM SHALL move to DECAY at the same edge.
REQ-022 On a DECAY tick, level SHALL become max(level-DECAY_STEP, SUSTAIN_LEVEL); on reaching SUSTAIN_LEVEL the FSM SHALL move to SUSTAIN at the same edge.
REQ-023 In SUSTAIN, the level SHALL hold at SUSTAIN_LEVEL.
REQ-024 On a RELEASE tick, level SHALL become max(level-RELEASE_STEP, 0); on reaching 0 the FSM SHALL move to IDLE at the same edge.
REQ-025 In IDLE, the level SHALL be 0.
REQ-026 Level arithmetic SHALL use at least 10 bits internally so that saturation occurs without wrap-around.
REQ-027 On each tick, sample_out SHALL be registered as (sample_in x level) >>> 8, using the pre-update level.
REQ-028 The product in REQ-027 SHALL be 27-bit signed, shifted arithmetically and truncated to 18 bits; it cannot overflow because level <= 256.
REQ-029 The latency from sample_in_valid to sample_out_valid SHALL be exactly 1 cycle.
REQ-030 sample_out_valid SHALL be a single-cycle pulse; consecutive-cycle valids SHALL each produce a pulse.
REQ-031 sample_out SHALL hold its value between pulses.
REQ-032 Samples SHALL be processed in IDLE with level 0, so sample_out=0 and sample_out_valid still pulses; the output sample cadence never stalls.

Reset
REQ-033 While reset=1, the outputs SHALL be: state IDLE, level 0, sample_out 0, sample_out_valid 0, env_level 0, envelope_active 0.
REQ-034 Reset SHALL take effect asynchronously and SHALL abort any in-progress envelope without completing it.
REQ-035 After reset deasserts, operation SHALL resume on the next clk edge.

Verification
REQ-036 Reset then 10 ticks of sample_in=1000 -> sample_out_valid pulses 1 cycle after each tick, sample_out=0, envelope_active=0.
REQ-037 note_on, then 64 ticks of sample_in=131071 -> env_level steps 4,8..256, DECAY entered at tick 64, and the 65th tick gives sample_out=131071 one cycle later.
REQ-038 Continue ticking after REQ-037 -> env_level 255..192 over 64 ticks, SUSTAIN entered; then sample_in=-131072 gives sample_out=-98304.
REQ-039 note_off in SUSTAIN -> 96 ticks to level 0, IDLE entered on the 96th tick, envelope_active falls the same edge.
REQ-040 note_on and note_off in the same cycle while in RELEASE at level 100 -> ATTACK with level 100; the next tick gives 104.
REQ-041 Assert reset asynchronously mid-ATTACK at level 40 -> all outputs are 0 before the next clk edge; a tick after release gives sample_out=0.
